branch_pred_tracker: RTL and testbench
======================================

// Module: branch_pred_tracker
// PURPOSE
//  Carries each fetched instruction's branch-target-buffer prediction (hit, predicted NPC, PC) from IF through ID into EX.
//  In EX it checks the prediction against the actual branch outcome and drives the PC redirect to the fetch PC mux.
//  Sits directly downstream of the BTB and issues its write/delete update commands.
//  Keeps prediction statistics counters.
// PARAMETERS
//  CNT_W    32  width of each statistics counter
//  STAT_EN  1   1 = counters enabled; 0 = counters tied to 0
// PORTS
//  clk           in   1      clock; all state updates on posedge
//  rst_n         in   1      reset, synchronous, active-low
//  bubbleF/D/E   in   1      stall for the IF/ID/EX stage register: hold contents
//  flushF/D/E    in   1      flush for the IF/ID/EX stage register: invalidate contents
//  pc_f          in   32     fetch PC
//  btb_hit_f     in   1      BTB hit for pc_f
//  btb_npc_f     in   32     BTB predicted target for pc_f
//  is_br_e       in   1      EX instruction is a conditional branch
//  jal_e         in   1      EX instruction is jal
//  jalr_e        in   1      EX instruction is jalr
//  br_taken_e    in   1      condition result for the EX branch
//  br_target_e   in   32     computed target of EX branch/jal/jalr
//  redirect      out  1      EX misprediction; fetch must load redirect_pc
//  redirect_pc   out  32     correct next PC
//  btb_write     out  1      allocate/update BTB entry
//  btb_delete    out  1      invalidate BTB entry
//  btb_upd_pc    out  32     PC of the entry to update
//  btb_upd_tgt   out  32     target to write
//  cnt_branch    out  CNT_W  resolved control-flow instructions (is_br_e|jal_e|jalr_e)
//  cnt_correct   out  CNT_W  resolved with correct prediction
//  cnt_mispred   out  CNT_W  redirects
// BEHAVIOUR
//  - Stage meta {valid, pc, hit, npc} is held in the ID register (meta_d) and the EX register (meta_e).
//    Per register, in priority order: rst_n=0 -> valid=0, fields 0; bubble -> hold; flush -> valid=0; else load from the previous stage.
//    meta_d loads {1, pc_f, btb_hit_f, btb_npc_f}; it uses bubbleD/flushD.
//    meta_e loads meta_d; it uses bubbleE/flushE.
//    A hit with flushF=1 loads into meta_d as valid=0.
//  - Resolve is combinational from meta_e and the EX inputs.
//    res = meta_e.valid & !bubbleE. Every output below is 0 when res=0.
//  - seq_pc = meta_e.pc + 4, modulo 2^32.
//  - Cases:
//    - Conditional branch: actual = taken ? br_target_e : seq_pc.
//    - jal/jalr: actual = br_target_e.
//    - Other instruction: actual = seq_pc.
//  - pred = meta_e.hit ? meta_e.npc : seq_pc. redirect = res & (pred != actual); redirect_pc = actual.
//  - btb_write = res & (is_br_e&taken | jal_e) & (!hit | npc!=br_target_e).
//    btb_upd_tgt = br_target_e.
//  - btb_delete = res & hit & ((is_br_e&!taken) | jalr_e | !(is_br_e|jal_e|jalr_e)).
//    jalr is never allocated.
//  - btb_write and btb_delete are mutually exclusive. btb_upd_pc = meta_e.pc.
//  - Counters are registered, +1 per res cycle under their condition, and wrap at 2^CNT_W. Reset clears them.
//    A stalled EX (bubbleE) never double-counts.
//  - Latency: prediction reaches EX 2 cycles after fetch, absent stalls. Redirect and BTB commands are visible the same cycle as resolve.
//  - Reset mid-operation: all meta invalid next cycle; no redirect until a new instruction reaches EX.
//  - Simultaneous bubbleX & flushX: bubble wins (hold).
// STRUCTURE
//  - Package bp_pkg:
//    - typedef bp_meta_t {valid, pc[31:0], hit, npc[31:0]}
//    - enum res_kind_e {RK_NONE, RK_COND, RK_JAL, RK_JALR}
//    - localparam PC_STEP = 4
//  - Sub-module bp_meta_reg: one stage register with bubble/flush/reset priority. Instantiated twice (D, E).
//  - Resolve logic and counters stay in the top module.
// TESTING
//  - Conditional branch pc=0x100, no BTB hit, taken to 0x140 -> redirect=1, redirect_pc=0x140, btb_write=1, upd_pc=0x100, upd_tgt=0x140.
//  - Same branch, hit npc=0x140, taken -> redirect=0, no write/delete, cnt_correct+1.
//  - Hit npc=0x140 but not taken -> redirect=1, redirect_pc=0x104, btb_delete=1, cnt_mispred+1.
//  - Non-branch pc=0x200 with hit npc=0x300 -> redirect_pc=0x204, btb_delete=1; cnt_branch unchanged.
//  - jalr, hit npc=0x80, target 0x90 -> redirect_pc=0x90, btb_delete=1, no write. jal at pc=0xFFFFFFFC with no hit -> seq_pc wraps to 0x0; write issued.
//  - Stall and flush ordering:
//    - Hold bubbleE 3 cycles on a resolving branch -> outputs 0, counters +1 once after release.
//    - flushD with hit in ID -> meta_e invalid next cycle.
//    - rst_n=0 mid-stream -> all counters 0, no redirect.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the branch-prediction tracker: per-stage prediction metadata
// and the classification of the instruction resolving in EX.
package bp_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        hit;
    logic [31:0] npc;
  } bp_meta_t;

  typedef enum logic [1:0] {RK_NONE, RK_COND, RK_JAL, RK_JALR} res_kind_e;

  // Control-flow decode flags are expected one-hot; jumps take precedence if not.
  function automatic res_kind_e res_kind(input logic is_br, input logic jal,
                                         input logic jalr);
    if (jalr)       return RK_JALR;
    else if (jal)   return RK_JAL;
    else if (is_br) return RK_COND;
    else            return RK_NONE;
  endfunction

endpackage

// File: rtl/bp_meta_reg.sv
// One pipeline register for prediction metadata.
// Priority: reset clears, bubble holds, flush invalidates, otherwise load.
module bp_meta_reg
  import bp_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     bubble_i,
  input  logic     flush_i,
  input  bp_meta_t load_i,
  output bp_meta_t meta_o
);

  bp_meta_t meta_q, meta_d;

  always_comb begin
    meta_d = meta_q;
    if (!bubble_i) begin
      if (flush_i) meta_d.valid = 1'b0;
      else         meta_d       = load_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) meta_q <= '0;
    else        meta_q <= meta_d;
  end

  assign meta_o = meta_q;

endmodule

// File: rtl/branch_pred_tracker.sv
// Carries BTB predictions IF->ID->EX, checks them at EX, drives the fetch
// redirect and BTB update commands, and keeps prediction statistics.
module branch_pred_tracker
  import bp_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter bit STAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bubbleF,
  input  logic             bubbleD,
  input  logic             bubbleE,
  input  logic             flushF,
  input  logic             flushD,
  input  logic             flushE,
  input  logic [31:0]      pc_f,
  input  logic             btb_hit_f,
  input  logic [31:0]      btb_npc_f,
  input  logic             is_br_e,
  input  logic             jal_e,
  input  logic             jalr_e,
  input  logic             br_taken_e,
  input  logic [31:0]      br_target_e,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             btb_write,
  output logic             btb_delete,
  output logic [31:0]      btb_upd_pc,
  output logic [31:0]      btb_upd_tgt,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_correct,
  output logic [CNT_W-1:0] cnt_mispred
);

  // There is no IF register here; the IF stall only matters upstream.
  logic unused_bubbleF;
  assign unused_bubbleF = bubbleF;

  bp_meta_t meta_f, meta_id, meta_ex;

  assign meta_f = '{valid: ~flushF, pc: pc_f, hit: btb_hit_f, npc: btb_npc_f};

  bp_meta_reg u_meta_d (
    .clk     (clk),
    .rst_n   (rst_n),
    .bubble_i(bubbleD),
    .flush_i (flushD),
    .load_i  (meta_f),
    .meta_o  (meta_id)
  );

  bp_meta_reg u_meta_e (
    .clk     (clk),
    .rst_n   (rst_n),
    .bubble_i(bubbleE),
    .flush_i (flushE),
    .load_i  (meta_id),
    .meta_o  (meta_ex)
  );

  // Resolve
  res_kind_e   kind;
  logic        res, is_cf, mispred, wr, del;
  logic [31:0] seq_pc, actual, pred;

  assign kind   = res_kind(is_br_e, jal_e, jalr_e);
  assign res    = meta_ex.valid & ~bubbleE;
  assign is_cf  = is_br_e | jal_e | jalr_e;
  assign seq_pc = meta_ex.pc + PC_STEP;
  assign pred   = meta_ex.hit ? meta_ex.npc : seq_pc;

  always_comb begin
    actual = seq_pc;
    case (kind)
      RK_COND:        actual = br_taken_e ? br_target_e : seq_pc;
      RK_JAL, RK_JALR: actual = br_target_e;
      default:        actual = seq_pc;
    endcase
  end

  assign mispred = res & (pred != actual);
  assign wr      = res & ((is_br_e & br_taken_e) | jal_e)
                       & (~meta_ex.hit | (meta_ex.npc != br_target_e));
  // jalr targets are data-dependent, so a stale jalr entry is dropped rather than rewritten.
  assign del     = res & meta_ex.hit & ~wr
                       & ((is_br_e & ~br_taken_e) | jalr_e | ~is_cf);

  assign redirect    = mispred;
  assign redirect_pc = res ? actual : '0;
  assign btb_write   = wr;
  assign btb_delete  = del;
  assign btb_upd_pc  = res ? meta_ex.pc : '0;
  assign btb_upd_tgt = res ? br_target_e : '0;

  // Statistics
  logic inc_branch, inc_correct, inc_mispred;
  assign inc_branch  = res & is_cf;
  assign inc_correct = res & is_cf & ~mispred;
  assign inc_mispred = mispred;

  if (STAT_EN) begin : g_stat
    logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
    logic [CNT_W-1:0] cnt_correct_q, cnt_correct_d;
    logic [CNT_W-1:0] cnt_mispred_q, cnt_mispred_d;

    always_comb begin
      cnt_branch_d  = cnt_branch_q  + (inc_branch  ? CNT_W'(1) : CNT_W'(0));
      cnt_correct_d = cnt_correct_q + (inc_correct ? CNT_W'(1) : CNT_W'(0));
      cnt_mispred_d = cnt_mispred_q + (inc_mispred ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_branch_q  <= '0;
        cnt_correct_q <= '0;
        cnt_mispred_q <= '0;
      end else begin
        cnt_branch_q  <= cnt_branch_d;
        cnt_correct_q <= cnt_correct_d;
        cnt_mispred_q <= cnt_mispred_d;
      end
    end

    assign cnt_branch  = cnt_branch_q;
    assign cnt_correct = cnt_correct_q;
    assign cnt_mispred = cnt_mispred_q;
  end else begin : g_nostat
    assign cnt_branch  = '0;
    assign cnt_correct = '0;
    assign cnt_mispred = '0;
  end

endmodule

// File: tb/tb_branch_pred_tracker.sv
// Bench for branch_pred_tracker: directed spec scenarios plus a randomized
// stream checked against a slot-level pipeline model.
module tb_branch_pred_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bubbleF, bubbleD, bubbleE, flushF, flushD, flushE;
  logic [31:0] pc_f, btb_npc_f, br_target_e;
  logic        btb_hit_f, is_br_e, jal_e, jalr_e, br_taken_e;
  logic        redirect, btb_write, btb_delete;
  logic [31:0] redirect_pc, btb_upd_pc, btb_upd_tgt;
  logic [31:0] cnt_branch, cnt_correct, cnt_mispred;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_pred_tracker #(.CNT_W(32), .STAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE),
    .flushF(flushF), .flushD(flushD), .flushE(flushE),
    .pc_f(pc_f), .btb_hit_f(btb_hit_f), .btb_npc_f(btb_npc_f),
    .is_br_e(is_br_e), .jal_e(jal_e), .jalr_e(jalr_e),
    .br_taken_e(br_taken_e), .br_target_e(br_target_e),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .btb_write(btb_write), .btb_delete(btb_delete),
    .btb_upd_pc(btb_upd_pc), .btb_upd_tgt(btb_upd_tgt),
    .cnt_branch(cnt_branch), .cnt_correct(cnt_correct), .cnt_mispred(cnt_mispred)
  );

  // Reference model: the instruction occupying each of ID and EX
  typedef struct {
    bit        v;
    bit [31:0] pc;
    bit        h;
    bit [31:0] npc;
  } slot_t;

  slot_t     m_id, m_ex;
  bit [31:0] m_branch, m_correct, m_mispred;
  bit        e_res, e_cf, e_redir, e_wr, e_del;
  bit [31:0] e_rpc, e_upc, e_utgt;

  function automatic void model_eval();
    bit [31:0] seq, act, pred;
    e_res = m_ex.v && !bubbleE;
    e_cf  = is_br_e || jal_e || jalr_e;
    seq   = m_ex.pc + 32'd4;
    if (jal_e || jalr_e) act = br_target_e;
    else if (is_br_e)    act = br_taken_e ? br_target_e : seq;
    else                 act = seq;
    pred    = m_ex.h ? m_ex.npc : seq;
    e_redir = e_res && (pred != act);
    e_rpc   = e_res ? act : 32'd0;
    e_wr    = e_res && ((is_br_e && br_taken_e) || jal_e) && (!m_ex.h || m_ex.npc != br_target_e);
    e_del   = e_res && m_ex.h && ((is_br_e && !br_taken_e) || jalr_e || !e_cf);
    e_upc   = e_res ? m_ex.pc : 32'd0;
    e_utgt  = e_res ? br_target_e : 32'd0;
  endfunction

  function automatic void model_step();
    model_eval();
    if (!rst_n) begin
      m_id = '{0, 0, 0, 0};
      m_ex = '{0, 0, 0, 0};
      m_branch = 0; m_correct = 0; m_mispred = 0;
    end else begin
      if (e_res && e_cf)             m_branch++;
      if (e_res && e_cf && !e_redir) m_correct++;
      if (e_redir)                   m_mispred++;
      if (!bubbleE) begin
        if (flushE) m_ex.v = 0;
        else        m_ex = m_id;
      end
      if (!bubbleD) begin
        if (flushD) m_id.v = 0;
        else        m_id = '{!flushF, pc_f, btb_hit_f, btb_npc_f};
      end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    {bubbleF, bubbleD, bubbleE, flushF, flushD, flushE} = '0;
    pc_f = 0; btb_hit_f = 0; btb_npc_f = 0;
    {is_br_e, jal_e, jalr_e, br_taken_e} = '0;
    br_target_e = 0;
  endtask

  // Fetch one instruction, then fill behind it with flushed slots until it sits in EX
  task automatic load_ex(input logic [31:0] pc, input logic hit, input logic [31:0] npc);
    idle_all();
    pc_f = pc; btb_hit_f = hit; btb_npc_f = npc;
    tick();
    flushF = 1; btb_hit_f = 0;
    tick();
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    checks++;
    if (redirect !== 1'b0 || btb_write !== 1'b0 || btb_delete !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got redir=%b wr=%b del=%b exp 0", redirect, btb_write, btb_delete);
    end
    checks++;
    if (cnt_branch !== 0 || cnt_correct !== 0 || cnt_mispred !== 0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d/%0d exp 0", cnt_branch, cnt_correct, cnt_mispred);
    end
  endtask

  task automatic test_cond_branch();
    logic [31:0] c0;
    // untrained taken branch
    load_ex(32'h100, 0, 0);
    is_br_e = 1; br_taken_e = 1; br_target_e = 32'h140;
    #1; checks++;
    if ({redirect, btb_write, btb_delete} !== 3'b110 || redirect_pc !== 32'h140 ||
        btb_upd_pc !== 32'h100 || btb_upd_tgt !== 32'h140) begin
      errors++; $display("FAIL cond_miss got r=%b w=%b d=%b rpc=%h upc=%h tgt=%h exp 1 1 0 140 100 140",
                         redirect, btb_write, btb_delete, redirect_pc, btb_upd_pc, btb_upd_tgt);
    end
    tick();
    // trained taken branch
    load_ex(32'h100, 1, 32'h140);
    is_br_e = 1; br_taken_e = 1; br_target_e = 32'h140;
    c0 = cnt_correct;
    #1; checks++;
    if ({redirect, btb_write, btb_delete} !== 3'b000) begin
      errors++; $display("FAIL cond_hit got r=%b w=%b d=%b exp 000", redirect, btb_write, btb_delete);
    end
    tick(); checks++;
    if (cnt_correct !== c0 + 1) begin
      errors++; $display("FAIL cond_hit_cnt got %0d exp %0d", cnt_correct, c0 + 1);
    end
    // trained but not taken
    load_ex(32'h100, 1, 32'h140);
    is_br_e = 1; br_taken_e = 0; br_target_e = 32'h140;
    c0 = cnt_mispred;
    #1; checks++;
    if ({redirect, btb_write, btb_delete} !== 3'b101 || redirect_pc !== 32'h104) begin
      errors++; $display("FAIL cond_nt got r=%b w=%b d=%b rpc=%h exp 1 0 1 104", redirect, btb_write, btb_delete, redirect_pc);
    end
    tick(); checks++;
    if (cnt_mispred !== c0 + 1) begin
      errors++; $display("FAIL cond_nt_cnt got %0d exp %0d", cnt_mispred, c0 + 1);
    end
  endtask

  task automatic test_non_branch();
    logic [31:0] c0;
    load_ex(32'h200, 1, 32'h300);
    c0 = cnt_branch;
    #1; checks++;
    if ({redirect, btb_write, btb_delete} !== 3'b101 || redirect_pc !== 32'h204) begin
      errors++; $display("FAIL nonbr_hit got r=%b w=%b d=%b rpc=%h exp 1 0 1 204", redirect, btb_write, btb_delete, redirect_pc);
    end
    tick(); checks++;
    if (cnt_branch !== c0) begin
      errors++; $display("FAIL nonbr_cnt got %0d exp %0d", cnt_branch, c0);
    end
  endtask

  task automatic test_jumps();
    load_ex(32'h400, 1, 32'h80);
    jalr_e = 1; br_target_e = 32'h90;
    #1; checks++;
    if ({redirect, btb_write, btb_delete} !== 3'b101 || redirect_pc !== 32'h90) begin
      errors++; $display("FAIL jalr got r=%b w=%b d=%b rpc=%h exp 1 0 1 90", redirect, btb_write, btb_delete, redirect_pc);
    end
    tick();
    load_ex(32'hFFFF_FFFC, 0, 0);
    jal_e = 1; br_target_e = 32'h10;
    #1; checks++;
    if ({redirect, btb_write, btb_delete} !== 3'b110 || redirect_pc !== 32'h10 || btb_upd_pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL jal_wrap got r=%b w=%b d=%b rpc=%h upc=%h exp 1 1 0 10 fffffffc",
                         redirect, btb_write, btb_delete, redirect_pc, btb_upd_pc);
    end
    tick();
    // fall-through at the top of the address space wraps to 0
    load_ex(32'hFFFF_FFFC, 1, 32'h50);
    is_br_e = 1; br_taken_e = 0; br_target_e = 32'h50;
    #1; checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h0 || btb_delete !== 1'b1) begin
      errors++; $display("FAIL seq_wrap got r=%b rpc=%h d=%b exp 1 0 1", redirect, redirect_pc, btb_delete);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] c0;
    load_ex(32'h100, 0, 0);
    is_br_e = 1; br_taken_e = 1; br_target_e = 32'h140;
    bubbleE = 1;
    c0 = cnt_branch;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if ({redirect, btb_write, btb_delete} !== 3'b000 || redirect_pc !== 0) begin
        errors++; $display("FAIL stall_out[%0d] got r=%b w=%b d=%b rpc=%h exp 0", i, redirect, btb_write, btb_delete, redirect_pc);
      end
      tick();
    end
    checks++;
    if (cnt_branch !== c0) begin
      errors++; $display("FAIL stall_cnt_hold got %0d exp %0d", cnt_branch, c0);
    end
    bubbleE = 0;
    #1; checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h140) begin
      errors++; $display("FAIL stall_release got r=%b rpc=%h exp 1 140", redirect, redirect_pc);
    end
    tick(); checks++;
    if (cnt_branch !== c0 + 1) begin
      errors++; $display("FAIL stall_cnt_once got %0d exp %0d", cnt_branch, c0 + 1);
    end
  endtask

  task automatic test_flush();
    idle_all();
    pc_f = 32'h200; btb_hit_f = 1; btb_npc_f = 32'h300; flushD = 1;
    tick();
    idle_all(); flushF = 1;
    tick();
    #1; checks++;
    if ({redirect, btb_write, btb_delete} !== 3'b000) begin
      errors++; $display("FAIL flushD got r=%b w=%b d=%b exp 000", redirect, btb_write, btb_delete);
    end
  endtask

  task automatic randomize_inputs();
    logic [31:0] tgts [4];
    int k;
    tgts[0] = 32'h140; tgts[1] = 32'h180; tgts[2] = 32'h200; tgts[3] = {$urandom} & 32'hFFFF_FFFC;
    bubbleF = ($urandom_range(0, 9) == 0);
    bubbleD = ($urandom_range(0, 5) == 0);
    bubbleE = ($urandom_range(0, 5) == 0);
    flushF  = ($urandom_range(0, 9) == 0);
    flushD  = ($urandom_range(0, 9) == 0);
    flushE  = ($urandom_range(0, 9) == 0);
    pc_f      = 32'h100 + ($urandom_range(0, 15) << 2);
    btb_hit_f = $urandom_range(0, 1);
    btb_npc_f = ($urandom_range(0, 4) == 0) ? pc_f + 4 : tgts[$urandom_range(0, 3)];
    k = $urandom_range(0, 3);
    is_br_e = (k == 1); jal_e = (k == 2); jalr_e = (k == 3);
    br_taken_e  = $urandom_range(0, 1);
    br_target_e = tgts[$urandom_range(0, 3)];
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      randomize_inputs();
      #1; model_eval();
      checks++;
      if (redirect !== e_redir || redirect_pc !== e_rpc) begin
        errors++; $display("FAIL rand_redirect[%0d] got %b/%h exp %b/%h", i, redirect, redirect_pc, e_redir, e_rpc);
      end
      checks++;
      if (btb_write !== e_wr || btb_delete !== e_del || btb_upd_pc !== e_upc || btb_upd_tgt !== e_utgt) begin
        errors++; $display("FAIL rand_btb[%0d] got w=%b d=%b pc=%h tgt=%h exp w=%b d=%b pc=%h tgt=%h",
                           i, btb_write, btb_delete, btb_upd_pc, btb_upd_tgt, e_wr, e_del, e_upc, e_utgt);
      end
      tick(); checks++;
      if (cnt_branch !== m_branch || cnt_correct !== m_correct || cnt_mispred !== m_mispred) begin
        errors++; $display("FAIL rand_cnt[%0d] got %0d/%0d/%0d exp %0d/%0d/%0d",
                           i, cnt_branch, cnt_correct, cnt_mispred, m_branch, m_correct, m_mispred);
      end
    end
  endtask

  task automatic test_reset_mid();
    test_random(20);
    randomize_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    randomize_inputs(); bubbleE = 0; jal_e = 1; is_br_e = 0; jalr_e = 0;
    for (int i = 0; i < 2; i++) begin
      #1; checks++;
      if (redirect !== 1'b0 || btb_write !== 1'b0 || btb_delete !== 1'b0) begin
        errors++; $display("FAIL rst_mid_out[%0d] got r=%b w=%b d=%b exp 0", i, redirect, btb_write, btb_delete);
      end
      checks++;
      if (cnt_branch !== 0 || cnt_correct !== 0 || cnt_mispred !== 0) begin
        errors++; $display("FAIL rst_mid_cnt[%0d] got %0d/%0d/%0d exp 0", i, cnt_branch, cnt_correct, cnt_mispred);
      end
      tick();
    end
    test_random(50);
  endtask

  initial begin
    m_id = '{0, 0, 0, 0};
    m_ex = '{0, 0, 0, 0};
    test_reset();
    test_cond_branch();
    test_non_branch();
    test_jumps();
    test_stall();
    test_flush();
    test_random(400);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
